booth_mul_sched: RTL

- Sequencer and round-robin arbiter that shares one radix-2 Booth multiplier datapath (M/Q/A registers, Q-1 bit, adder/subtractor, arithmetic shifter) between N_REQ requesters.
- Accepts operand pairs, drives the datapath load/add/sub/shift strobes with an internal iteration counter, and returns the 2*WIDTH product tagged with the requester id over a valid/ready channel.
- Sits between client blocks and the multiplier datapath.
- Replaces the external-count style of control.

---
 rtl/booth_mul_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler and sequencer for a shared radix-2 Booth multiplier datapath.
// Grants one requester at a time, steps the datapath strobes and returns the tagged product.
module booth_mul_sched #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_m,
   input  logic [N_REQ*WIDTH-1:0] req_q,
   output logic [N_REQ-1:0]       gnt,
   output logic                   busy,
   output logic [WIDTH-1:0]       op_m,
   output logic [WIDTH-1:0]       op_q,
   output logic                   ld,
   output logic                   add,
   output logic                   sub,
   output logic                   shift,
   input  logic                   q0,
   input  logic                   qm,
   input  logic [WIDTH-1:0]       dp_a,
   input  logic [WIDTH-1:0]       dp_q,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [2*WIDTH-1:0]     rsp_data,
   output logic [IDW-1:0]         rsp_id
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_SHIFT, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [IDW-1:0]   r_ptr, r_id;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_op_m, r_op_q;

   logic             w_found, w_hi_found;
   logic [IDW-1:0]   w_win, w_hi, w_lo;
   logic [WIDTH-1:0] w_sel_m, w_sel_q;

   // Lowest set bit at or above r_ptr wins; otherwise wrap to the lowest set bit overall.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      w_hi_found = 1'b0;
      w_hi       = '0;
      w_lo       = '0;
      w_sel_m    = '0;
      w_sel_q    = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            w_lo = IDW'(j);
            if (IDW'(j) >= r_ptr) begin
               w_hi_found = 1'b1;
               w_hi       = IDW'(j);
            end
         end
      end
      w_found = |req;
      w_win   = w_hi_found ? w_hi : w_lo;
      for (int j = 0; j < N_REQ; j++) begin
         if (IDW'(j) == w_win) begin
            w_sel_m = req_m[j*WIDTH +: WIDTH];
            w_sel_q = req_q[j*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      w_next = r_state;
      gnt    = '0;
      ld     = 1'b0;
      add    = 1'b0;
      sub    = 1'b0;
      shift  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               gnt[w_win] = 1'b1;
               w_next     = S_LOAD;
            end
         end
         S_LOAD: begin
            ld     = 1'b1;
            w_next = S_SCAN;
         end
         S_SCAN: begin
            add    = ({q0, qm} == 2'b01);
            sub    = ({q0, qm} == 2'b10);
            w_next = S_SHIFT;
         end
         S_SHIFT: begin
            shift  = 1'b1;
            w_next = (r_cnt == CW'(1)) ? S_DONE : S_SCAN;
         end
         S_DONE: begin
            if (rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_cnt   <= '0;
         r_op_m  <= '0;
         r_op_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         r_state <= w_next;
         if (r_state == S_IDLE && w_found) begin
            r_op_m <= w_sel_m;
            r_op_q <= w_sel_q;
            r_id   <= w_win;
            r_ptr  <= (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
         end
         if (r_state == S_LOAD) r_cnt <= CW'(WIDTH);
         else if (r_state == S_SHIFT) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = (r_state == S_DONE);
   assign rsp_data  = {dp_a, dp_q};
   assign rsp_id    = r_id;
   assign op_m      = r_op_m;
   assign op_q      = r_op_q;

endmodule
